slc3_ctrl: RTL and testbench
============================

SLC3_CTRL -- requirements
Module: slc3_ctrl

Interface
REQ-001 Clk  input  1  sole clock, all state on rising edge.
REQ-002 Reset_ah  input  1  synchronous, active-high reset.
REQ-003 Run  input  1  start request, sampled only in HALTED.
REQ-004 Continue  input  1  resume request for PAUSE states.
REQ-005 IR  input  16  current instruction: opcode IR[15:12], IR[11] = JSR/JSRR select.
REQ-006 BEN  input  1  branch-enable from the NZP/IR[11:9] compare.
REQ-007 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  output  1 each  register load strobes.
REQ-008 GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers, at most one high per cycle.
REQ-009 PCMUX  output  2  00 = PC+1, 01 = bus, 10 = address adder.
REQ-010 DRMUX  output  1  0 = IR[11:9], 1 = R7; feeds the register file's destination select.
REQ-011 SR1MUX  output  1  0 = IR[11:9], 1 = IR[8:6]; feeds the register file's source-1 select.
REQ-012 SR2MUX  output  1  0 = register SR2, 1 = sext(IR[4:0]).
REQ-013 ADDR1MUX  output  1  0 = PC, 1 = SR1.
REQ-014 ADDR2MUX  output  2  00 = 0, 01 = off6, 10 = off9, 11 = off11.
REQ-015 ALUK  output  2  00 = ADD, 01 = AND, 10 = NOT, 11 = PASSA.
REQ-016 Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  output  1 each  active-low SRAM controls.

Function
REQ-017 Moore machine: outputs SHALL be decoded from the registered state only, never directly from Run, Continue, IR or BEN.
REQ-018 Output defaults: all strobes, gates and mux selects 0; Mem_CE, Mem_OE and Mem_WE 1; Mem_UB and Mem_LB 0.
REQ-019 HALTED: hold while Run = 0; Run = 1 -> S18.
REQ-020 S18: LD_MAR, GatePC, LD_PC, PCMUX = 00 -> S33_1.
REQ-021 S33_1, S33_2, S33_3: Mem_CE = 0, Mem_OE = 0; LD_MDR in S33_3 only; fixed 3-cycle read; S33_3 -> S35.
REQ-022 S35: GateMDR, LD_IR -> S32.
REQ-023 S32: LD_BEN; dispatch on IR[15:12]:
- 0001 ADD -> S01; 0101 AND -> S05; 1001 NOT -> S09
- 0000 BR -> S00; 1100 JMP -> S12; 0100 JSR -> S04
- 0110 LDR -> S06; 0111 STR -> S07; 1101 PAUSE -> PAUSE1
- any other opcode -> S18 (treated as NOP)
REQ-024 S01 / S05 / S09: GateALU, LD_REG, LD_CC, SR1MUX = 1, DRMUX = 0; SR2MUX = IR[5] for ADD and AND; ALUK = 00 / 01 / 10 respectively; -> S18.
REQ-025 S00: BEN = 1 -> S22, else -> S18; S22: LD_PC, PCMUX = 10, ADDR1MUX = 0, ADDR2MUX = 10 -> S18.
REQ-026 S12: LD_PC, PCMUX = 10, ADDR1MUX = 1, ADDR2MUX = 00, SR1MUX = 1 -> S18.
REQ-027 S04: GatePC, LD_REG, DRMUX = 1 (R7 <- PC) -> S21.
REQ-028 S21: LD_PC, PCMUX = 10:
- IR[11] = 1: ADDR1MUX = 0, ADDR2MUX = 11
- IR[11] = 0: ADDR1MUX = 1, ADDR2MUX = 00, SR1MUX = 1
- -> S18
REQ-029 S06 and S07: GateMARMUX, LD_MAR, ADDR1MUX = 1, ADDR2MUX = 01, SR1MUX = 1.
REQ-030 Load path: S06 -> S25_1..S25_3 (same signalling as S33_x) -> S27; S27: GateMDR, LD_REG, LD_CC, DRMUX = 0 -> S18.
REQ-031 Store path: S07 -> S23; S23: GateALU, ALUK = 11, SR1MUX = 0, LD_MDR -> S16_1.
REQ-032 S16_1..S16_3: Mem_CE = 0, Mem_WE = 0 for all three cycles -> S18.
REQ-033 PAUSE1: LD_LED; hold until Continue = 1 -> PAUSE2; PAUSE2: hold until Continue = 0 -> S18. A held Continue SHALL NOT advance more than one PAUSE instruction.
REQ-034 Run asserted outside HALTED SHALL be ignored.

Reset
REQ-035 Reset_ah = 1 at a rising edge SHALL force HALTED, from any state, including mid-memory-cycle; outputs take defaults that same cycle.
REQ-036 Reset SHALL take priority over Run and Continue in the same cycle.

Structure
REQ-037 Package slc3_ctrl_pkg SHALL hold the state enum, opcode constants, and PCMUX/ADDR2MUX/ALUK encodings.
REQ-038 Single module with two processes: state register and combinational next-state/output; no sub-module.

Verification
REQ-039 Reset, then Run pulse -> S18 next cycle; LD_MAR = 1, GatePC = 1; Mem_OE = 0 for exactly 3 cycles; LD_IR one cycle after S33_3.
REQ-040 IR = 16'h1283 (ADD R1,R2,R3) -> S01: LD_REG = 1, SR1MUX = 1, SR2MUX = 0, ALUK = 00, then S18.
REQ-041 IR = 16'h0E05 with BEN = 0 -> S00 -> S18, LD_PC stays 0; same IR with BEN = 1 -> S22 with PCMUX = 10, ADDR2MUX = 10.
REQ-042 IR = 16'h7442 (STR) -> S07, S23, then Mem_WE = 0 for 3 cycles; Mem_OE stays 1 throughout.
REQ-043 IR = 16'hD000 with Continue held 1 for 10 cycles -> stays PAUSE2; Continue = 0 -> S18 next edge.
REQ-044 Reset_ah pulsed during S25_2 -> HALTED next edge; all LD_* = 0, Mem_CE = 1; a new Run restarts at S18.

Source files
------------

// File: rtl/slc3_ctrl_pkg.sv
// Shared types and encodings for the SLC-3 control unit.
// Holds the state enum, opcode constants and datapath mux encodings.
package slc3_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_HALTED,
    ST_S18,
    ST_S33_1,
    ST_S33_2,
    ST_S33_3,
    ST_S35,
    ST_S32,
    ST_S01,
    ST_S05,
    ST_S09,
    ST_S00,
    ST_S22,
    ST_S12,
    ST_S04,
    ST_S21,
    ST_S06,
    ST_S25_1,
    ST_S25_2,
    ST_S25_3,
    ST_S27,
    ST_S07,
    ST_S23,
    ST_S16_1,
    ST_S16_2,
    ST_S16_3,
    ST_PAUSE1,
    ST_PAUSE2
  } state_e;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage

// File: rtl/slc3_ctrl.sv
// SLC-3 Moore control FSM: fetch, decode and execute sequencing with fixed 3-cycle SRAM accesses.
// Outputs depend only on registered state; PAUSE waits for a full Continue press/release.
module slc3_ctrl
  import slc3_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  ALUK,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  state_e state_q, state_d;
  // IR[5] and IR[11] are captured at dispatch so execute-state outputs stay pure functions of flops.
  logic   ir5_q, ir5_d;
  logic   ir11_q, ir11_d;

  logic unused_ir;
  assign unused_ir = ^{IR[10:6], IR[4:0]};

  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      state_q <= ST_HALTED;
      ir5_q   <= 1'b0;
      ir11_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir5_q   <= ir5_d;
      ir11_q  <= ir11_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir5_d      = ir5_q;
    ir11_d     = ir11_q;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = PCMUX_PC1;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = ADDR2_ZERO;
    ALUK       = ALUK_ADD;
    Mem_CE     = 1'b1;
    Mem_UB     = 1'b0;
    Mem_LB     = 1'b0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;

    unique case (state_q)
      ST_HALTED: if (Run) state_d = ST_S18;
      ST_S18: begin
        LD_MAR  = 1'b1;
        GatePC  = 1'b1;
        LD_PC   = 1'b1;
        PCMUX   = PCMUX_PC1;
        state_d = ST_S33_1;
      end
      ST_S33_1, ST_S33_2, ST_S33_3, ST_S25_1, ST_S25_2, ST_S25_3: begin
        Mem_CE = 1'b0;
        Mem_OE = 1'b0;
        LD_MDR = (state_q == ST_S33_3) || (state_q == ST_S25_3);
        case (state_q)
          ST_S33_1: state_d = ST_S33_2;
          ST_S33_2: state_d = ST_S33_3;
          ST_S33_3: state_d = ST_S35;
          ST_S25_1: state_d = ST_S25_2;
          ST_S25_2: state_d = ST_S25_3;
          default:  state_d = ST_S27;
        endcase
      end
      ST_S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
        state_d = ST_S32;
      end
      ST_S32: begin
        LD_BEN = 1'b1;
        ir5_d  = IR[5];
        ir11_d = IR[11];
        case (IR[15:12])
          OP_ADD:   state_d = ST_S01;
          OP_AND:   state_d = ST_S05;
          OP_NOT:   state_d = ST_S09;
          OP_BR:    state_d = ST_S00;
          OP_JMP:   state_d = ST_S12;
          OP_JSR:   state_d = ST_S04;
          OP_LDR:   state_d = ST_S06;
          OP_STR:   state_d = ST_S07;
          OP_PAUSE: state_d = ST_PAUSE1;
          default:  state_d = ST_S18;
        endcase
      end
      ST_S01, ST_S05, ST_S09: begin
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        SR1MUX  = 1'b1;
        SR2MUX  = (state_q != ST_S09) && ir5_q;
        ALUK    = (state_q == ST_S01) ? ALUK_ADD :
                  (state_q == ST_S05) ? ALUK_AND : ALUK_NOT;
        state_d = ST_S18;
      end
      ST_S00: state_d = BEN ? ST_S22 : ST_S18;
      ST_S22: begin
        LD_PC    = 1'b1;
        PCMUX    = PCMUX_ADDR;
        ADDR2MUX = ADDR2_OFF9;
        state_d  = ST_S18;
      end
      ST_S12: begin
        LD_PC    = 1'b1;
        PCMUX    = PCMUX_ADDR;
        ADDR1MUX = 1'b1;
        SR1MUX   = 1'b1;
        state_d  = ST_S18;
      end
      ST_S04: begin
        GatePC  = 1'b1;
        LD_REG  = 1'b1;
        DRMUX   = 1'b1;
        state_d = ST_S21;
      end
      ST_S21: begin
        LD_PC    = 1'b1;
        PCMUX    = PCMUX_ADDR;
        ADDR1MUX = !ir11_q;
        SR1MUX   = !ir11_q;
        ADDR2MUX = ir11_q ? ADDR2_OFF11 : ADDR2_ZERO;
        state_d  = ST_S18;
      end
      ST_S06, ST_S07: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = ADDR2_OFF6;
        SR1MUX     = 1'b1;
        state_d    = (state_q == ST_S06) ? ST_S25_1 : ST_S23;
      end
      ST_S27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        state_d = ST_S18;
      end
      ST_S23: begin
        GateALU = 1'b1;
        ALUK    = ALUK_PASSA;
        LD_MDR  = 1'b1;
        state_d = ST_S16_1;
      end
      ST_S16_1, ST_S16_2, ST_S16_3: begin
        Mem_CE  = 1'b0;
        Mem_WE  = 1'b0;
        state_d = (state_q == ST_S16_1) ? ST_S16_2 :
                  (state_q == ST_S16_2) ? ST_S16_3 : ST_S18;
      end
      ST_PAUSE1: begin
        LD_LED = 1'b1;
        if (Continue) state_d = ST_PAUSE2;
      end
      ST_PAUSE2: if (!Continue) state_d = ST_S18;
      default: state_d = ST_HALTED;
    endcase
  end

endmodule

// File: tb/tb_slc3_ctrl.sv
// Directed bench for slc3_ctrl: a named-state reference model checked every cycle plus literal spot checks.
module tb_slc3_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_ah, Run, Continue, BEN;
  logic [15:0] IR;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  int    checks = 0;
  int    errors = 0;
  string model_st = "X";

  slc3_ctrl dut (
    .Clk(Clk), .Reset_ah(Reset_ah), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  logic [26:0] dut_word;
  assign dut_word = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                     GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                     ADDR1MUX, ADDR2MUX, ALUK, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};

  function automatic string mnext(string s, logic rst, logic run, logic cont,
                                  logic [15:0] ir, logic ben);
    if (rst) return "HALTED";
    if (s == "HALTED") return run ? "S18" : "HALTED";
    if (s == "S18")    return "S33_1";
    if (s == "S33_1")  return "S33_2";
    if (s == "S33_2")  return "S33_3";
    if (s == "S33_3")  return "S35";
    if (s == "S35")    return "S32";
    if (s == "S32") begin
      case (ir[15:12])
        4'h1: return "S01";
        4'h5: return "S05";
        4'h9: return "S09";
        4'h0: return "S00";
        4'hC: return "S12";
        4'h4: return "S04";
        4'h6: return "S06";
        4'h7: return "S07";
        4'hD: return "PAUSE1";
        default: return "S18";
      endcase
    end
    if (s == "S00")    return ben ? "S22" : "S18";
    if (s == "S04")    return "S21";
    if (s == "S06")    return "S25_1";
    if (s == "S25_1")  return "S25_2";
    if (s == "S25_2")  return "S25_3";
    if (s == "S25_3")  return "S27";
    if (s == "S07")    return "S23";
    if (s == "S23")    return "S16_1";
    if (s == "S16_1")  return "S16_2";
    if (s == "S16_2")  return "S16_3";
    if (s == "PAUSE1") return cont ? "PAUSE2" : "PAUSE1";
    if (s == "PAUSE2") return cont ? "PAUSE2" : "S18";
    if (s == "X")      return "X";
    return "S18";
  endfunction

  function automatic logic [26:0] exp_word(string s, logic [15:0] ir);
    logic ld_mar = 0, ld_mdr = 0, ld_ir = 0, ld_ben = 0, ld_cc = 0, ld_reg = 0, ld_pc = 0, ld_led = 0;
    logic g_pc = 0, g_mdr = 0, g_alu = 0, g_marmux = 0;
    logic [1:0] pcmux = 0, a2 = 0, aluk = 0;
    logic drmux = 0, sr1 = 0, sr2 = 0, a1 = 0;
    logic ce = 1, oe = 1, we = 1;
    if (s == "S18") begin ld_mar = 1; g_pc = 1; ld_pc = 1; end
    if (s == "S33_1" || s == "S33_2" || s == "S33_3" ||
        s == "S25_1" || s == "S25_2" || s == "S25_3") begin ce = 0; oe = 0; end
    if (s == "S33_3" || s == "S25_3") ld_mdr = 1;
    if (s == "S35") begin g_mdr = 1; ld_ir = 1; end
    if (s == "S32") ld_ben = 1;
    if (s == "S01" || s == "S05" || s == "S09") begin
      g_alu = 1; ld_reg = 1; ld_cc = 1; sr1 = 1;
      sr2  = (s == "S09") ? 1'b0 : ir[5];
      aluk = (s == "S01") ? 2'd0 : (s == "S05") ? 2'd1 : 2'd2;
    end
    if (s == "S22") begin ld_pc = 1; pcmux = 2; a2 = 2; end
    if (s == "S12") begin ld_pc = 1; pcmux = 2; a1 = 1; sr1 = 1; end
    if (s == "S04") begin g_pc = 1; ld_reg = 1; drmux = 1; end
    if (s == "S21") begin
      ld_pc = 1; pcmux = 2;
      if (ir[11]) a2 = 3;
      else begin a1 = 1; sr1 = 1; end
    end
    if (s == "S06" || s == "S07") begin g_marmux = 1; ld_mar = 1; a1 = 1; a2 = 1; sr1 = 1; end
    if (s == "S27") begin g_mdr = 1; ld_reg = 1; ld_cc = 1; end
    if (s == "S23") begin g_alu = 1; aluk = 3; ld_mdr = 1; end
    if (s == "S16_1" || s == "S16_2" || s == "S16_3") begin ce = 0; we = 0; end
    if (s == "PAUSE1") ld_led = 1;
    return {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led,
            g_pc, g_mdr, g_alu, g_marmux, pcmux, drmux, sr1, sr2, a1, a2, aluk,
            ce, 1'b0, 1'b0, oe, we};
  endfunction

  always @(posedge Clk) model_st <= mnext(model_st, Reset_ah, Run, Continue, IR, BEN);

  always @(negedge Clk) begin
    if (model_st != "X") begin
      logic [26:0] e;
      e = exp_word(model_st, IR);
      checks++;
      if (dut_word !== e) begin
        errors++;
        $display("FAIL model[%s] t=%0t: outputs %07h, required %07h", model_st, $time, dut_word, e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // From S18, load IR/BEN and advance to the state following dispatch.
  task automatic to_exec(input logic [15:0] ir, input logic ben);
    IR  = ir;
    BEN = ben;
    tick(6);
  endtask

  initial begin
    int oe_cnt, we_cnt, oe_low;
    Reset_ah = 1; Run = 0; Continue = 0; BEN = 0; IR = 16'h0000;
    tick(2);
    chk("reset_ld",  32'({LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED}), 0);
    chk("reset_mem", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'b10011);

    Reset_ah = 0; Run = 1; IR = 16'h1283;
    tick(1);
    chk("s18_ldmar_gatepc", 32'({LD_MAR, GatePC}), 32'b11);
    Run = 0;
    oe_cnt = 0;
    for (int i = 0; i < 3; i++) begin tick(1); if (Mem_OE == 1'b0) oe_cnt++; end
    tick(1);
    chk("fetch_oe_cycles", 32'(oe_cnt), 3);
    chk("s35_ld_ir", 32'({LD_IR, Mem_OE}), 32'b11);
    tick(1);
    chk("s32_ld_ben", 32'(LD_BEN), 1);
    tick(1);
    chk("add_ctrl", 32'({LD_REG, SR1MUX, SR2MUX, ALUK}), 32'b11000);
    tick(1);
    chk("add_back_s18", 32'(LD_MAR), 1);

    to_exec(16'h0E05, 1'b0);
    chk("br_nt_ldpc", 32'(LD_PC), 0);
    tick(1);
    chk("br_nt_s18", 32'(LD_MAR), 1);
    to_exec(16'h0E05, 1'b1);
    tick(1);
    chk("br_t_s22", 32'({LD_PC, PCMUX, ADDR1MUX, ADDR2MUX}), 32'b1_10_0_10);
    tick(1);

    Run = 1;
    to_exec(16'h5265, 1'b0);
    chk("and_imm", 32'({SR2MUX, ALUK}), 32'b1_01);
    tick(1);
    Run = 0;
    to_exec(16'h927F, 1'b0);
    chk("not_aluk", 32'(ALUK), 2);
    tick(1);
    to_exec(16'hC080, 1'b0);
    chk("jmp_ctrl", 32'({LD_PC, PCMUX, ADDR1MUX, SR1MUX}), 32'b1_10_1_1);
    tick(1);
    to_exec(16'h4800, 1'b0);
    chk("jsr_s04", 32'({GatePC, LD_REG, DRMUX}), 32'b111);
    tick(1);
    chk("jsr_s21", 32'({ADDR1MUX, ADDR2MUX}), 32'b0_11);
    tick(1);
    to_exec(16'h4080, 1'b0);
    tick(1);
    chk("jsrr_s21", 32'({ADDR1MUX, ADDR2MUX, SR1MUX}), 32'b1_00_1);
    tick(1);
    to_exec(16'hF025, 1'b0);
    chk("nop_to_s18", 32'({LD_MAR, GateALU}), 32'b10);

    to_exec(16'h7442, 1'b0);
    chk("str_s07", 32'({GateMARMUX, LD_MAR, ADDR2MUX, Mem_OE}), 32'b1_1_01_1);
    tick(1);
    chk("str_s23", 32'({GateALU, ALUK, LD_MDR, SR1MUX, Mem_OE}), 32'b1_11_1_0_1);
    we_cnt = 0; oe_low = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (Mem_WE == 1'b0) we_cnt++;
      if (Mem_OE == 1'b0) oe_low++;
    end
    tick(1);
    chk("str_we_cycles", 32'(we_cnt), 3);
    chk("str_oe_high", 32'(oe_low), 0);
    chk("str_back_s18", 32'({LD_MAR, Mem_WE}), 32'b11);

    to_exec(16'hD000, 1'b0);
    chk("pause1_led", 32'(LD_LED), 1);
    Continue = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("pause2_hold", 32'({LD_LED, LD_MAR}), 0);
    end
    Continue = 0;
    tick(1);
    chk("pause_release_s18", 32'(LD_MAR), 1);
    Continue = 1;
    to_exec(16'hD000, 1'b0);
    tick(4);
    chk("pause_held_cont", 32'({LD_LED, LD_MAR}), 0);
    Continue = 0;
    tick(1);

    to_exec(16'h6442, 1'b0);
    chk("ldr_s06", 32'({GateMARMUX, ADDR2MUX}), 32'b1_01);
    tick(4);
    chk("ldr_s27", 32'({GateMDR, LD_REG, LD_CC}), 32'b111);
    tick(1);
    to_exec(16'h6442, 1'b0);
    tick(2);
    chk("ldr_s25_2_oe", 32'(Mem_OE), 0);
    Reset_ah = 1; Run = 1; Continue = 1;
    tick(1);
    chk("midmem_reset_ld", 32'({LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED}), 0);
    chk("midmem_reset_mem", 32'({Mem_CE, Mem_OE, GatePC}), 32'b110);
    Reset_ah = 0; Continue = 0;
    tick(1);
    chk("restart_s18", 32'({LD_MAR, GatePC}), 32'b11);
    Run = 0;
    tick(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
